// File: rtl/vision_ctrl.sv
// Frame-synchronous control for the vision pipeline: switch debounce, shadowed
// Cb/Cr thresholds committed only at frame start, and a free-running frame counter.
module vision_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  TA_INIT         = 8'd70,
    parameter logic [7:0]  TB_INIT         = 8'd130,
    parameter logic [7:0]  TC_INIT         = 8'd140,
    parameter logic [7:0]  TD_INIT         = 8'd190
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sw,
    input  logic        vsync_in,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic        cfg_ready,
    output logic [3:0]  mode_out,
    output logic [7:0]  ta,
    output logic [7:0]  tb,
    output logic [7:0]  tc,
    output logic [7:0]  td,
    output logic        cfg_pending,
    output logic        cfg_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;

    state_t      state;
    logic [3:0]  sw_p0, sw_p1, sw_cand, sw_stable;
    logic [15:0] db_cnt;
    logic        vs_d1, vs_d2;
    logic        frame_start;
    logic        rst_done;
    logic        accept;
    logic        thr_ok;
    logic [7:0]  sh_ta, sh_tb, sh_tc, sh_td;

    function automatic logic thr_valid(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return (a < b) && (c < d);
    endfunction

    assign frame_start = vs_d1 && !vs_d2;
    assign cfg_ready   = rst_done && (state != COMMIT) && !frame_start;
    assign accept      = cfg_valid && cfg_ready;
    assign thr_ok      = thr_valid(sh_ta, sh_tb, sh_tc, sh_td);

    // Switch synchroniser and debounce; counter saturates once the candidate is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_p0     <= 4'd0;
            sw_p1     <= 4'd0;
            sw_cand   <= 4'd0;
            sw_stable <= 4'd0;
            db_cnt    <= 16'd0;
        end else begin
            sw_p0 <= sw;
            sw_p1 <= sw_p0;
            if (sw_p1 != sw_cand) begin
                sw_cand <= sw_p1;
                db_cnt  <= 16'd0;
            end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                sw_stable <= sw_cand;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    // Frame-start detection, mode latch and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1     <= 1'b0;
            vs_d2     <= 1'b0;
            rst_done  <= 1'b0;
            mode_out  <= 4'd0;
            frame_cnt <= 16'd0;
        end else begin
            vs_d1    <= vsync_in;
            vs_d2    <= vs_d1;
            rst_done <= 1'b1;
            if (frame_start) begin
                mode_out  <= sw_stable;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Write FSM, shadows and active thresholds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            ta          <= TA_INIT;
            tb          <= TB_INIT;
            tc          <= TC_INIT;
            td          <= TD_INIT;
            sh_ta       <= TA_INIT;
            sh_tb       <= TB_INIT;
            sh_tc       <= TC_INIT;
            sh_td       <= TD_INIT;
        end else begin
            if (accept) begin
                case (cfg_addr)
                    2'd0:    sh_ta <= cfg_data;
                    2'd1:    sh_tb <= cfg_data;
                    2'd2:    sh_tc <= cfg_data;
                    default: sh_td <= cfg_data;
                endcase
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= ARMED;
                        cfg_pending <= 1'b1;
                    end
                end
                ARMED: begin
                    // accept is never high here when frame_start is, so the reload cannot race a write
                    if (frame_start) begin
                        state       <= COMMIT;
                        cfg_pending <= 1'b0;
                        if (thr_ok) begin
                            ta      <= sh_ta;
                            tb      <= sh_tb;
                            tc      <= sh_tc;
                            td      <= sh_td;
                            cfg_err <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                            sh_ta   <= ta;
                            sh_tb   <= tb;
                            sh_tc   <= tc;
                            sh_td   <= td;
                        end
                    end
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vision_ctrl.sv
// Directed bench for vision_ctrl: reset, shadow commit/reject, write/frame collision,
// debounce and frame counter wrap, with hand-computed expectations.
module tb_vision_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw;
    logic        vsync_in;
    logic        cfg_valid;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic [3:0]  mode_out;
    logic [7:0]  ta, tb, tc, td;
    logic        cfg_pending;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          exp_fc       = 0;

    always #5 clk = ~clk;

    vision_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .TA_INIT(8'd70),
        .TB_INIT(8'd130),
        .TC_INIT(8'd140),
        .TD_INIT(8'd190)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sw),
        .vsync_in(vsync_in),
        .cfg_valid(cfg_valid),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_ready(cfg_ready),
        .mode_out(mode_out),
        .ta(ta),
        .tb(tb),
        .tc(tc),
        .td(td),
        .cfg_pending(cfg_pending),
        .cfg_err(cfg_err),
        .frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        while (!cfg_ready && n < 20) begin
            step(1);
            n++;
        end
        if (n >= 20) check("wr_timeout", 32'(n), 0);
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic frame();
        vsync_in = 1'b1;
        step(2);
        exp_fc++;
        vsync_in = 1'b0;
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sw = 4'd0; vsync_in = 1'b0;
        cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
        step(3);
        check("rst_ready", 32'(cfg_ready), 0);
        check("rst_ta", 32'(ta), 70);
        check("rst_tb", 32'(tb), 130);
        check("rst_tc", 32'(tc), 140);
        check("rst_td", 32'(td), 190);
        check("rst_mode", 32'(mode_out), 0);
        check("rst_fc", 32'(frame_cnt), 0);
        check("rst_pend", 32'(cfg_pending), 0);
        check("rst_err", 32'(cfg_err), 0);
        rst_n = 1'b1;
        check("rel_ready0", 32'(cfg_ready), 0);
        step(1);
        check("rel_ready1", 32'(cfg_ready), 1);

        // reset in the middle of a pending write discards the shadow
        cfg_write(2'd0, 8'd10);
        check("mid_pend", 32'(cfg_pending), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pend", 32'(cfg_pending), 0);
        check("mid_rst_ready", 32'(cfg_ready), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("mid_rel_ready", 32'(cfg_ready), 1);

        // single write, detailed frame timing
        cfg_write(2'd2, 8'd150);
        check("w_pend", 32'(cfg_pending), 1);
        check("w_tc_held", 32'(tc), 140);
        vsync_in = 1'b1;
        step(1);
        check("fs_ready", 32'(cfg_ready), 0);
        check("fs_tc_held", 32'(tc), 140);
        step(1);
        exp_fc++;
        check("c_tc", 32'(tc), 150);
        check("c_ta_discard", 32'(ta), 70);
        check("commit_ready", 32'(cfg_ready), 0);
        check("c_pend", 32'(cfg_pending), 0);
        check("c_fc", 32'(frame_cnt), 32'(exp_fc));
        step(1);
        check("post_ready", 32'(cfg_ready), 1);
        vsync_in = 1'b0;
        step(2);

        // two-register commit
        cfg_write(2'd0, 8'd60);
        cfg_write(2'd1, 8'd120);
        check("c2_pend", 32'(cfg_pending), 1);
        check("c2_ta_held", 32'(ta), 70);
        check("c2_tb_held", 32'(tb), 130);
        frame();
        check("c2_ta", 32'(ta), 60);
        check("c2_tb", 32'(tb), 120);
        check("c2_err", 32'(cfg_err), 0);

        // reject, shadow reload, then equality reject
        cfg_write(2'd0, 8'd200);
        frame();
        check("rj_ta", 32'(ta), 60);
        check("rj_err", 32'(cfg_err), 1);
        check("rj_pend", 32'(cfg_pending), 0);
        cfg_write(2'd1, 8'd125);
        frame();
        check("rl_ta", 32'(ta), 60);
        check("rl_tb", 32'(tb), 125);
        check("rl_err", 32'(cfg_err), 0);
        cfg_write(2'd0, 8'd125);
        frame();
        check("eq_ta", 32'(ta), 60);
        check("eq_err", 32'(cfg_err), 1);

        // write accepted in the cycle before frame_start: one-cycle ARMED
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd90; vsync_in = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        check("oc_pend", 32'(cfg_pending), 1);
        step(1);
        exp_fc++;
        check("oc_ta", 32'(ta), 90);
        check("oc_err", 32'(cfg_err), 0);
        vsync_in = 1'b0;
        step(2);

        // write held across frame_start and COMMIT
        cfg_write(2'd3, 8'd200);
        vsync_in = 1'b1;
        step(1);
        cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd160;
        check("col_fs_ready", 32'(cfg_ready), 0);
        step(1);
        exp_fc++;
        check("col_td", 32'(td), 200);
        check("col_tc", 32'(tc), 150);
        check("col_cm_ready", 32'(cfg_ready), 0);
        step(1);
        check("col_pend0", 32'(cfg_pending), 0);
        check("col_ready", 32'(cfg_ready), 1);
        step(1);
        cfg_valid = 1'b0;
        check("col_pend1", 32'(cfg_pending), 1);
        check("col_tc_held", 32'(tc), 150);
        vsync_in = 1'b0;
        step(2);
        frame();
        check("col_tc_next", 32'(tc), 160);

        // debounce: 2-cycle glitch to 3 must be ignored
        sw = 4'h2;
        step(1);
        sw = 4'h3;
        step(2);
        sw = 4'h2;
        step(2);
        frame();
        check("db_early", 32'(mode_out), 0);
        step(3);
        check("db_no_fs", 32'(mode_out), 0);
        frame();
        check("db_mode", 32'(mode_out), 2);
        check("fc_total", 32'(frame_cnt), 32'(exp_fc));

        // wrap with held vsync
        step(2);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        check("wr_pre", 32'(frame_cnt), 32'hFFFF);
        vsync_in = 1'b1;
        step(1);
        check("wr_e0", 32'(frame_cnt), 32'hFFFF);
        step(1);
        check("wr_e1", 32'(frame_cnt), 0);
        step(8);
        check("wr_held", 32'(frame_cnt), 0);
        vsync_in = 1'b0;
        step(2);
        check("wr_end", 32'(frame_cnt), 0);
        check("wr_mode", 32'(mode_out), 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
